// File: rtl/dmem_write_buffer_if.sv
// Signal bundle between the L1 data cache, the write buffer and Dmem.
// The buffer uses the slave view; the environment around it (cache + Dmem)
// uses the master view.
interface dmem_write_buffer_if #(
    parameter int ADDR_W  = 10,
    parameter int BLOCK_W = 128
);
    // cache -> buffer: evictions
    logic               wb_valid;
    logic [ADDR_W-1:0]  wb_addr;
    logic [BLOCK_W-1:0] wb_data;
    logic               wb_accept;
    // cache -> buffer: read misses
    logic               rd_req;
    logic [ADDR_W-1:0]  rd_addr;
    logic               rd_valid;
    logic [BLOCK_W-1:0] rd_data;
    // status
    logic               empty;
    logic               full;
    // buffer -> Dmem
    logic               mem_ren;
    logic               mem_wen;
    logic [ADDR_W-1:0]  mem_addr;
    logic [BLOCK_W-1:0] mem_din;
    logic               mem_ready;
    logic               mem_done;
    logic [BLOCK_W-1:0] mem_dout;

    modport slave (
        input  wb_valid, wb_addr, wb_data, rd_req, rd_addr,
               mem_ready, mem_done, mem_dout,
        output wb_accept, rd_valid, rd_data, empty, full,
               mem_ren, mem_wen, mem_addr, mem_din
    );

    modport master (
        output wb_valid, wb_addr, wb_data, rd_req, rd_addr,
               mem_ready, mem_done, mem_dout,
        input  wb_accept, rd_valid, rd_data, empty, full,
               mem_ren, mem_wen, mem_addr, mem_din
    );
endinterface

// File: rtl/dmem_write_buffer.sv
// Victim/write-back buffer between the L1 data cache and Dmem.
// Dirty evictions are queued in a small circular FIFO and drained to Dmem in
// eviction order when no read miss is waiting. Read misses that match a queued
// block are forwarded from the buffer; other misses go to Dmem ahead of drains.
module dmem_write_buffer #(
    parameter int ADDR_W  = 10,
    parameter int BLOCK_W = 128,
    parameter int DEPTH   = 4,
    parameter int PTR_W   = 2
) (
    input  logic               clock,
    input  logic               reset,
    dmem_write_buffer_if.slave bus
);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [DEPTH-1:0]   valid_q, valid_d;
    logic [ADDR_W-1:0]  addr_q [DEPTH];
    logic [ADDR_W-1:0]  addr_d [DEPTH];
    logic [BLOCK_W-1:0] data_q [DEPTH];
    logic [BLOCK_W-1:0] data_d [DEPTH];
    logic               empty_q, empty_d;
    logic               full_q, full_d;
    logic               mem_ren_q, mem_ren_d;
    logic               mem_wen_q, mem_wen_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [BLOCK_W-1:0] mem_din_q, mem_din_d;
    logic               rd_valid_q, rd_valid_d;
    logic [BLOCK_W-1:0] rd_data_q, rd_data_d;

    logic               accept_s;
    logic               pop_s;
    logic               append_s;
    logic               drain_start_s;
    logic               head_lock_s;
    logic               rd_hit_s;
    logic [PTR_W-1:0]   rd_hit_idx_s;
    logic               wb_hit_s;
    logic [PTR_W-1:0]   wb_hit_idx_s;

    // Physical slot that is k entries younger than the head (wraps modulo DEPTH).
    function automatic logic [PTR_W-1:0] slot_of(input logic [PTR_W-1:0] base, input int k);
        return base + PTR_W'(k);
    endfunction

    // Accept decision uses the registered full flag, so a slot freed this edge
    // is only offered again on the following cycle.
    assign accept_s      = bus.wb_valid && !full_q && !reset;
    // A drain is launched from IDLE when no read is waiting.
    assign drain_start_s = (state_q == ST_IDLE) && !bus.rd_req && !empty_q;
    // The head is locked while it is being written to Dmem, including the cycle
    // the write is launched (its data is captured into mem_din at that edge).
    assign head_lock_s   = (state_q == ST_WR) || drain_start_s;

    // Address match against queued entries; scanning oldest to youngest so the
    // last match is the youngest one.
    always_comb begin
        rd_hit_s     = 1'b0;
        rd_hit_idx_s = head_q;
        wb_hit_s     = 1'b0;
        wb_hit_idx_s = head_q;
        for (int k = 0; k < DEPTH; k++) begin
            if (valid_q[slot_of(head_q, k)] && (addr_q[slot_of(head_q, k)] == bus.rd_addr)) begin
                rd_hit_s     = 1'b1;
                rd_hit_idx_s = slot_of(head_q, k);
            end else begin
                rd_hit_s     = rd_hit_s;
            end
            if (valid_q[slot_of(head_q, k)] && (addr_q[slot_of(head_q, k)] == bus.wb_addr)
                && ((k != 0) || !head_lock_s)) begin
                wb_hit_s     = 1'b1;
                wb_hit_idx_s = slot_of(head_q, k);
            end else begin
                wb_hit_s     = wb_hit_s;
            end
        end
    end

    // Next-state logic: read/drain sequencing and FIFO bookkeeping.
    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        tail_d     = tail_q;
        valid_d    = valid_q;
        addr_d     = addr_q;
        data_d     = data_q;
        mem_ren_d  = mem_ren_q;
        mem_wen_d  = mem_wen_q;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        pop_s      = 1'b0;
        append_s   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.rd_req) begin
                    if (rd_hit_s) begin
                        rd_data_d  = data_q[rd_hit_idx_s];
                        rd_valid_d = 1'b1;
                        state_d    = ST_GAP;
                    end else begin
                        mem_ren_d  = 1'b1;
                        mem_addr_d = bus.rd_addr;
                        state_d    = ST_RD;
                    end
                end else if (!empty_q) begin
                    mem_wen_d  = 1'b1;
                    mem_addr_d = addr_q[head_q];
                    mem_din_d  = data_q[head_q];
                    state_d    = ST_WR;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_RD: begin
                if (bus.mem_ready) begin
                    rd_data_d  = bus.mem_dout;
                    rd_valid_d = 1'b1;
                    mem_ren_d  = 1'b0;
                    state_d    = ST_GAP;
                end else begin
                    state_d    = ST_RD;
                end
            end
            ST_WR: begin
                if (bus.mem_done) begin
                    pop_s      = 1'b1;
                    mem_wen_d  = 1'b0;
                    state_d    = ST_GAP;
                end else begin
                    state_d    = ST_WR;
                end
            end
            ST_GAP: begin
                // One quiet cycle so Dmem restarts its delay counter.
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                mem_ren_d = 1'b0;
                mem_wen_d = 1'b0;
            end
        endcase

        if (pop_s) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_W'(1'b1);
        end else begin
            head_d          = head_q;
        end

        if (accept_s) begin
            if (wb_hit_s) begin
                data_d[wb_hit_idx_s] = bus.wb_data;
            end else begin
                append_s         = 1'b1;
                valid_d[tail_q]  = 1'b1;
                addr_d[tail_q]   = bus.wb_addr;
                data_d[tail_q]   = bus.wb_data;
                tail_d           = tail_q + PTR_W'(1'b1);
            end
        end else begin
            tail_d = tail_q;
        end

        count_d = count_q + CNT_W'(append_s) - CNT_W'(pop_s);
        empty_d = (count_d == {CNT_W{1'b0}});
        full_d  = (count_d == CNT_W'(DEPTH));
    end

    // State registers; reset clears the queue and abandons any Dmem access.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            head_q     <= {PTR_W{1'b0}};
            tail_q     <= {PTR_W{1'b0}};
            count_q    <= {CNT_W{1'b0}};
            valid_q    <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= {ADDR_W{1'b0}};
                data_q[i] <= {BLOCK_W{1'b0}};
            end
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            mem_ren_q  <= 1'b0;
            mem_wen_q  <= 1'b0;
            mem_addr_q <= {ADDR_W{1'b0}};
            mem_din_q  <= {BLOCK_W{1'b0}};
            rd_valid_q <= 1'b0;
            rd_data_q  <= {BLOCK_W{1'b0}};
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            mem_ren_q  <= mem_ren_d;
            mem_wen_q  <= mem_wen_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign bus.wb_accept = accept_s;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.empty     = empty_q;
    assign bus.full      = full_q;
    assign bus.mem_ren   = mem_ren_q;
    assign bus.mem_wen   = mem_wen_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_din   = mem_din_q;
endmodule
